// File: rtl/std_seq_mult_5.sv
// Iterative unsigned shift-add multiplier with a go/done handshake.
// One partial product is added per cycle, so a WIDTH x WIDTH product
// (truncated to WIDTH bits) needs WIDTH busy cycles and a single adder.
// `done` is a registered one-cycle pulse, and `out` holds the last product.
module std_seq_mult_5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_sum;

  // Next-state logic: accept in IDLE, one shift-add step per BUSY cycle,
  // publish the product on the last step, then spend one cycle in DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    done_d   = 1'b0;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (go) begin
          mcand_d  = left;
          mplier_d = right;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == LAST_ITER) begin
          // The counter returns to zero so it never exceeds WIDTH-1.
          cnt_d   = '0;
          out_d   = acc_sum;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // go is deliberately not looked at here, so a held go restarts
        // only after returning to IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset that
  // overrides everything, including an operation already in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_std_seq_mult_5.sv
// Self-checking bench for std_seq_mult_5: a table of directed operand
// pairs with hand-computed products, plus hand-written sequences for
// reset, ignored inputs while busy, held go and mid-operation reset.
module tb_std_seq_mult_5;

  localparam int WIDTH = 5;

  logic             clk;
  logic             reset;
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out;
  logic             done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  std_seq_mult_5 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .left  (left),
    .right (right),
    .out   (out),
    .done  (done)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic g, input logic [WIDTH-1:0] l,
                               input logic [WIDTH-1:0] r);
    go    = g;
    left  = l;
    right = r;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // One full operation: accept, wait (bounded) for done, check latency,
  // product, the falling edge of done and that out holds afterwards.
  task automatic runOp(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input logic [WIDTH-1:0] exp_out, input string tag);
    int cycles;
    applyStimulus(1'b1, l, r);
    step();
    applyStimulus(1'b0, ~l, ~r);
    cycles = 0;
    while (!done && cycles < 12) begin
      step();
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, WIDTH);
    checkOutput({tag, "_out"}, int'(out), int'(exp_out));
    step();
    checkOutput({tag, "_done_fall"}, int'(done), 0);
    checkOutput({tag, "_out_hold"}, int'(out), int'(exp_out));
  endtask

  initial begin
    int pulses;
    int done_cycle;
    int consec;
    logic prev_done;

    vecs[0] = '{a: 5'd3,  b: 5'd7,  exp_out: 5'd21};
    vecs[1] = '{a: 5'd6,  b: 5'd7,  exp_out: 5'd10};
    vecs[2] = '{a: 5'd31, b: 5'd31, exp_out: 5'd1};
    vecs[3] = '{a: 5'd0,  b: 5'd19, exp_out: 5'd0};
    vecs[4] = '{a: 5'd19, b: 5'd0,  exp_out: 5'd0};
    vecs[5] = '{a: 5'd1,  b: 5'd31, exp_out: 5'd31};
    vecs[6] = '{a: 5'd16, b: 5'd2,  exp_out: 5'd0};
    vecs[7] = '{a: 5'd5,  b: 5'd6,  exp_out: 5'd30};

    // Reset held low with go asserted: nothing may start.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd7, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput($sformatf("reset_out_c%0d", i), int'(out), 0);
      checkOutput($sformatf("reset_done_c%0d", i), int'(done), 0);
    end

    // Release with go still high: the first edge with reset high accepts.
    reset = 1'b1;
    step();
    applyStimulus(1'b0, 5'd0, 5'd0);
    done_cycle = 0;
    while (!done && done_cycle < 12) begin
      step();
      done_cycle++;
    end
    checkOutput("release_latency", done_cycle, WIDTH);
    checkOutput("release_out", int'(out), 21);
    step();
    checkOutput("release_done_fall", int'(done), 0);

    // Table of directed products.
    for (int v = 0; v < 8; v++) begin
      runOp(vecs[v].a, vecs[v].b, vecs[v].exp_out, $sformatf("vec%0d", v));
    end

    // go and operands toggled during BUSY must have no effect.
    applyStimulus(1'b1, 5'd5, 5'd5);
    step();
    pulses = 0;
    done_cycle = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 2 || i == 3) applyStimulus(1'b1, 5'd1, 5'd1);
      else applyStimulus(1'b0, 5'd1, 5'd1);
      step();
      if (done) begin
        pulses++;
        if (done_cycle < 0) done_cycle = i;
        checkOutput("busy_ignore_out", int'(out), 25);
      end
    end
    checkOutput("busy_ignore_pulses", pulses, 1);
    checkOutput("busy_ignore_done_cycle", done_cycle, WIDTH);
    checkOutput("busy_ignore_out_after", int'(out), 25);

    // Held go: a new product every WIDTH+2 cycles, done never doubled.
    applyStimulus(1'b1, 5'd2, 5'd9);
    step();
    consec = 0;
    prev_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checkOutput($sformatf("held_done_c%0d", i), int'(done), ((i % 7) == 5) ? 1 : 0);
      if (done) checkOutput($sformatf("held_out_c%0d", i), int'(out), 18);
      if (done && prev_done) consec++;
      prev_done = done;
    end
    checkOutput("held_no_consecutive_done", consec, 0);
    applyStimulus(1'b0, 5'd0, 5'd0);
    step();
    step();

    // Reset on the third BUSY edge discards the 9*3 product.
    applyStimulus(1'b1, 5'd9, 5'd3);
    step();
    applyStimulus(1'b0, 5'd9, 5'd3);
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("midreset_out", int'(out), 0);
    checkOutput("midreset_done", int'(done), 0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) pulses++;
    end
    checkOutput("midreset_no_done", pulses, 0);
    checkOutput("midreset_out_stays", int'(out), 0);
    runOp(5'd4, 5'd4, 5'd16, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
